// File: rtl/mult16_seq_if.sv
`default_nettype none
// ============================================================================
// mult16_seq_if : request/result bus and 8x8-stage handshake for mult16_seq
// Rev 1.0
// ============================================================================
interface mult16_seq_if;
  logic        start;
  logic        sgn;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] RES;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_done;
  logic [15:0] mul_res;

  modport master (
    output start, sgn, A, B, mul_done, mul_res,
    input  busy, done, err, RES, mul_start, mul_a, mul_b
  );

  modport slave (
    input  start, sgn, A, B, mul_done, mul_res,
    output busy, done, err, RES, mul_start, mul_a, mul_b
  );
endinterface

`default_nettype wire

// File: rtl/mult16_seq.sv
`default_nettype none
// ============================================================================
// mult16_seq : sequential 16x16 signed/unsigned multiply from four 8x8 partials
// Optional per-partial timeout abort when MULT16_TIMEOUT_EN is defined.
// Rev 1.0
// ============================================================================
module mult16_seq #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  mult16_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_ACC   = 3'd4,
    S_FIX   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_sgn;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_mag_a;
  logic [15:0] r_mag_b;
  logic        r_neg;
  logic [31:0] r_acc;
  logic [1:0]  r_idx;
  logic [15:0] r_prod;
  logic        r_mul_done;
  logic [7:0]  r_mul_a;
  logic [7:0]  r_mul_b;
  logic [31:0] r_res;

  logic [15:0] w_mag_a;
  logic [15:0] w_mag_b;
  logic        w_rise;
  logic [31:0] w_partial;
  logic [1:0]  w_idx_inc;
  logic        w_timeout;

  // Two's-complement negate of 0x8000 yields 0x8000, which read unsigned is 32768.
  assign w_mag_a   = (r_sgn && r_a[15]) ? (16'd0 - r_a) : r_a;
  assign w_mag_b   = (r_sgn && r_b[15]) ? (16'd0 - r_b) : r_b;
  assign w_rise    = bus.mul_done & ~r_mul_done;
  assign w_idx_inc = r_idx + 2'd1;

  always_comb begin
    w_partial = {16'd0, r_prod};
    case (r_idx)
      2'd1, 2'd2: w_partial = {8'd0, r_prod, 8'd0};
      2'd3:       w_partial = {r_prod, 16'd0};
      default:    w_partial = {16'd0, r_prod};
    endcase
  end

`ifdef MULT16_TIMEOUT_EN
  logic [3:0] r_tcnt;
  logic       r_err;
  logic [4:0] w_tcnt_inc;

  assign w_tcnt_inc = {1'b0, r_tcnt} + 5'd1;
  assign w_timeout  = (r_state == S_WAIT) && !w_rise && (w_tcnt_inc == 5'(TIMEOUT));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tcnt <= 4'd0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_tcnt <= 4'd0;
      end else if (r_state == S_WAIT && !w_rise) begin
        r_tcnt <= w_tcnt_inc[3:0];
      end
      if (r_state == S_IDLE && bus.start) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.err = r_err;
`else
  // TIMEOUT only matters in the timeout build.
  logic [3:0] unused_timeout;
  assign unused_timeout = 4'(TIMEOUT);
  assign w_timeout      = 1'b0;
  assign bus.err        = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_PREP;
      S_PREP:  w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_rise) begin
          w_state_nxt = S_ACC;
        end else if (w_timeout) begin
          w_state_nxt = S_DONE;
        end
      end
      S_ACC:   w_state_nxt = (r_idx == 2'd3) ? S_FIX : S_ISSUE;
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sgn      <= 1'b0;
      r_a        <= 16'd0;
      r_b        <= 16'd0;
      r_mag_a    <= 16'd0;
      r_mag_b    <= 16'd0;
      r_neg      <= 1'b0;
      r_acc      <= 32'd0;
      r_idx      <= 2'd0;
      r_prod     <= 16'd0;
      r_mul_done <= 1'b0;
      r_mul_a    <= 8'd0;
      r_mul_b    <= 8'd0;
      r_res      <= 32'd0;
    end else begin
      r_mul_done <= bus.mul_done;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a   <= bus.A;
            r_b   <= bus.B;
            r_sgn <= bus.sgn;
          end
        end
        S_PREP: begin
          r_mag_a <= w_mag_a;
          r_mag_b <= w_mag_b;
          r_neg   <= r_sgn & (r_a[15] ^ r_b[15]);
          r_acc   <= 32'd0;
          r_idx   <= 2'd0;
          r_mul_a <= w_mag_a[7:0];
          r_mul_b <= w_mag_b[7:0];
        end
        S_WAIT: begin
          if (w_rise) begin
            r_prod <= bus.mul_res;
          end else if (w_timeout) begin
            r_res <= 32'd0;
          end
        end
        S_ACC: begin
          r_acc <= r_acc + w_partial;
          // Operands for the next partial are loaded here so they are stable at ISSUE.
          if (r_idx != 2'd3) begin
            r_idx   <= w_idx_inc;
            r_mul_a <= w_idx_inc[1] ? r_mag_a[15:8] : r_mag_a[7:0];
            r_mul_b <= w_idx_inc[0] ? r_mag_b[15:8] : r_mag_b[7:0];
          end
        end
        S_FIX: begin
          r_res <= r_neg ? (32'd0 - r_acc) : r_acc;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.mul_start = (r_state == S_ISSUE);
  assign bus.mul_a     = r_mul_a;
  assign bus.mul_b     = r_mul_b;
  assign bus.RES       = r_res;

endmodule

`default_nettype wire
